// File: rtl/tone_generator.sv
// tone_generator
//   Square-wave tone generator fed by the piano controller's registered note
//   code. Each note maps to a half-period count derived from CLK_HZ. Note
//   changes and rests are only accepted at full-period boundaries, so the
//   speaker never emits a truncated pulse.
//
//   Optional feature macro: TONE_HIGH_OCTAVE_EN
//     defined     -> codes 8..14 play C5..B5 (half-period = base >> 1)
//     not defined -> codes 8..14 behave as rest
//
//   Ports
//     clk       in   1  system clock, rising edge
//     reset     in   1  asynchronous, active-high reset
//     note_in   in   4  0 = rest, 1..7 = C4..B4, 8..14 = C5..B5, 15 = rest
//     speaker   out  1  square-wave audio output (registered)
//     playing   out  1  high while a note is sounding (registered)
//     note_cur  out  4  note code currently sounding, 0 when idle
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | silent, waiting for a valid note code
//   HIGH  | first half of the period, speaker high, note_in ignored
//   LOW   | second half of the period, note_in sampled at its last cycle

module tone_generator #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] note_in,
    output logic       speaker,
    output logic       playing,
    output logic [3:0] note_cur
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    function automatic logic [23:0] calc_half(input int unsigned freq,
                                              input int unsigned shift);
        int unsigned h;
        h = (CLK_HZ / (2 * freq)) >> shift;
        if (h < 1) h = 1;
        return h[23:0];
    endfunction

    localparam logic [23:0] HALF_1 = calc_half(262, 0);
    localparam logic [23:0] HALF_2 = calc_half(294, 0);
    localparam logic [23:0] HALF_3 = calc_half(330, 0);
    localparam logic [23:0] HALF_4 = calc_half(349, 0);
    localparam logic [23:0] HALF_5 = calc_half(392, 0);
    localparam logic [23:0] HALF_6 = calc_half(440, 0);
    localparam logic [23:0] HALF_7 = calc_half(494, 0);
`ifdef TONE_HIGH_OCTAVE_EN
    localparam logic [23:0] HALF_8  = calc_half(262, 1);
    localparam logic [23:0] HALF_9  = calc_half(294, 1);
    localparam logic [23:0] HALF_10 = calc_half(330, 1);
    localparam logic [23:0] HALF_11 = calc_half(349, 1);
    localparam logic [23:0] HALF_12 = calc_half(392, 1);
    localparam logic [23:0] HALF_13 = calc_half(440, 1);
    localparam logic [23:0] HALF_14 = calc_half(494, 1);
`endif

    function automatic logic is_valid(input logic [3:0] n);
`ifdef TONE_HIGH_OCTAVE_EN
        return (n != 4'd0) && (n != 4'd15);
`else
        return (n >= 4'd1) && (n <= 4'd7);
`endif
    endfunction

    logic [1:0]  state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  note_q, note_d;
    logic        speaker_q, speaker_d;
    logic        playing_q, playing_d;
    logic [23:0] half_sel;
    logic [23:0] half_m1;
    logic        note_ok;

    always_comb begin
        half_sel = 24'd1;
        case (note_q)
            4'd1:    half_sel = HALF_1;
            4'd2:    half_sel = HALF_2;
            4'd3:    half_sel = HALF_3;
            4'd4:    half_sel = HALF_4;
            4'd5:    half_sel = HALF_5;
            4'd6:    half_sel = HALF_6;
            4'd7:    half_sel = HALF_7;
`ifdef TONE_HIGH_OCTAVE_EN
            4'd8:    half_sel = HALF_8;
            4'd9:    half_sel = HALF_9;
            4'd10:   half_sel = HALF_10;
            4'd11:   half_sel = HALF_11;
            4'd12:   half_sel = HALF_12;
            4'd13:   half_sel = HALF_13;
            4'd14:   half_sel = HALF_14;
`endif
            default: half_sel = 24'd1;
        endcase
        half_m1 = half_sel - 24'd1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        note_d  = note_q;
        note_ok = is_valid(note_in);
        case (state_q)
            IDLE: begin
                cnt_d  = 24'd0;
                note_d = 4'd0;
                if (note_ok) begin
                    note_d  = note_in;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (cnt_q == half_m1) begin
                    cnt_d   = 24'd0;
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            LOW: begin
                if (cnt_q == half_m1) begin
                    // period boundary: the only point where note_in is taken
                    cnt_d = 24'd0;
                    if (note_ok) begin
                        note_d  = note_in;
                        state_d = HIGH;
                    end else begin
                        note_d  = 4'd0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 24'd0;
                note_d  = 4'd0;
            end
        endcase
        // outputs are registered copies of the next-state decode
        speaker_d = (state_d == HIGH);
        playing_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 24'd0;
            note_q    <= 4'd0;
            speaker_q <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            note_q    <= note_d;
            speaker_q <= speaker_d;
            playing_q <= playing_d;
        end
    end

    assign speaker  = speaker_q;
    assign playing  = playing_q;
    assign note_cur = note_q;

endmodule
